// File: rtl/inv_dir_arbiter.sv
// rtl/inv_dir_arbiter.sv - round-robin arbiter sharing one 1/dir reciprocal divider among ray-setup requesters
// Directions are packed {x,y,z}, x in the top WIDTH bits; requester i owns req_dir[i*3*WIDTH +: 3*WIDTH].
module inv_dir_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 16,
  parameter int Q_BITS  = 12,
  parameter int TIMEOUT = 64,
  localparam int ID_W   = $clog2(N_REQ),
  localparam int DIR_W  = 3 * WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*DIR_W-1:0] req_dir,
  input  logic [N_REQ-1:0]       req_skip,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   div_start,
  output logic [DIR_W-1:0]       div_dir,
  output logic                   div_skip,
  input  logic                   div_valid,
  input  logic [DIR_W-1:0]       div_dir_in,
  input  logic                   div_skip_in,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [DIR_W-1:0]       rsp_dir,
  output logic                   rsp_skip,
  output logic                   rsp_err,
  output logic                   busy,
  output logic                   err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT);

  if (N_REQ < 2) begin : g_bad_nreq
    $error("inv_dir_arbiter: N_REQ must be at least 2");
  end
  if (TIMEOUT <= WIDTH + Q_BITS + 2) begin : g_bad_timeout
    $error("inv_dir_arbiter: TIMEOUT must exceed the divider latency");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    rr_q, rr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [DIR_W-1:0]   dir_q, dir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIR_W-1:0]   rsp_dir_q, rsp_dir_d;
  logic               rsp_skip_q, rsp_skip_d;
  logic               rsp_err_q, rsp_err_d;
  logic               err_to_q, err_to_d;

  logic               gnt_found;
  logic [ID_W-1:0]    gnt_idx;
  logic [ID_W:0]      idx_ext;

  // First requester at or after rr_q, wrapping modulo N_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx_ext   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx_ext = {1'b0, rr_q} + (ID_W+1)'(i);
      if (idx_ext >= (ID_W+1)'(N_REQ)) idx_ext = idx_ext - (ID_W+1)'(N_REQ);
      if (!gnt_found && req_valid[idx_ext[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx_ext[ID_W-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    id_d       = id_q;
    dir_d      = dir_q;
    cnt_d      = cnt_q;
    rsp_dir_d  = rsp_dir_q;
    rsp_skip_d = rsp_skip_q;
    rsp_err_d  = rsp_err_q;
    err_to_d   = err_to_q;
    req_ready  = '0;
    div_start  = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          req_ready[gnt_idx] = 1'b1;
          id_d  = gnt_idx;
          dir_d = req_dir[gnt_idx*DIR_W +: DIR_W];
          rr_d  = (gnt_idx == ID_W'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
          if (req_skip[gnt_idx]) begin
            rsp_dir_d  = '0;
            rsp_skip_d = 1'b1;
            rsp_err_d  = 1'b0;
            state_d    = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        div_start = 1'b1;
        cnt_d     = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        // A result arriving on the limit cycle still counts as a success.
        if (div_valid) begin
          rsp_dir_d  = div_dir_in;
          rsp_skip_d = div_skip_in;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT-1)) begin
          err_to_d   = 1'b1;
          rsp_dir_d  = '0;
          rsp_skip_d = 1'b1;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      id_q       <= '0;
      dir_q      <= '0;
      cnt_q      <= '0;
      rsp_dir_q  <= '0;
      rsp_skip_q <= 1'b0;
      rsp_err_q  <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      id_q       <= id_d;
      dir_q      <= dir_d;
      cnt_q      <= cnt_d;
      rsp_dir_q  <= rsp_dir_d;
      rsp_skip_q <= rsp_skip_d;
      rsp_err_q  <= rsp_err_d;
      err_to_q   <= err_to_d;
    end
  end

  // Skipped rays never reach the divider, so its skip input is always clear.
  assign div_skip    = 1'b0;
  assign div_dir     = dir_q;
  assign rsp_valid   = (state_q == RESP);
  assign rsp_id      = id_q;
  assign rsp_dir     = rsp_dir_q;
  assign rsp_skip    = rsp_skip_q;
  assign rsp_err     = rsp_err_q;
  assign busy        = (state_q != IDLE);
  assign err_timeout = err_to_q;

endmodule

// File: tb/tb_inv_dir_arbiter.sv
// tb/tb_inv_dir_arbiter.sv - directed bench for inv_dir_arbiter with a stub divider
module tb_inv_dir_arbiter;

  localparam int N_REQ = 4;
  localparam int WIDTH = 16;
  localparam int DIR_W = 3 * WIDTH;
  localparam int LAT   = 28;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*DIR_W-1:0] req_dir;
  logic [N_REQ-1:0]       req_skip;
  logic [N_REQ-1:0]       req_ready;
  logic                   div_start;
  logic [DIR_W-1:0]       div_dir;
  logic                   div_skip;
  logic                   div_valid;
  logic [DIR_W-1:0]       div_dir_in;
  logic                   div_skip_in;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [1:0]             rsp_id;
  logic [DIR_W-1:0]       rsp_dir;
  logic                   rsp_skip;
  logic                   rsp_err;
  logic                   busy;
  logic                   err_timeout;

  logic                   stub_en;
  logic                   stub_valid;
  logic [DIR_W-1:0]       stub_dir;
  int                     lat_cnt;
  logic                   man_valid;
  logic [DIR_W-1:0]       man_dir;
  int                     start_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inv_dir_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .Q_BITS(12), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_dir(req_dir), .req_skip(req_skip), .req_ready(req_ready),
    .div_start(div_start), .div_dir(div_dir), .div_skip(div_skip),
    .div_valid(div_valid), .div_dir_in(div_dir_in), .div_skip_in(div_skip_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_dir(rsp_dir),
    .rsp_skip(rsp_skip), .rsp_err(rsp_err), .busy(busy), .err_timeout(err_timeout)
  );

  assign div_valid  = stub_valid | man_valid;
  assign div_dir_in = man_valid ? man_dir : stub_dir;

  // Stub divider: fixed latency, returns {x,z,y} of the divisor so pass-through is visible.
  always @(posedge clk) begin
    stub_valid <= 1'b0;
    if (reset) begin
      lat_cnt <= 0;
      stub_dir <= '0;
    end else if (div_start && stub_en) begin
      lat_cnt <= LAT;
    end else if (lat_cnt > 0) begin
      lat_cnt <= lat_cnt - 1;
      if (lat_cnt == 1) begin
        stub_valid <= 1'b1;
        stub_dir   <= {div_dir[47:32], div_dir[15:0], div_dir[31:16]};
      end
    end
  end

  always @(posedge clk) if (div_start) start_cnt <= start_cnt + 1;

  function automatic logic [DIR_W-1:0] mk(input logic [15:0] x, y, z);
    return {x, y, z};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!rsp_valid && n < 300) begin
      step();
      n++;
    end
    chk(tag, {63'd0, rsp_valid}, 64'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  logic [DIR_W-1:0] dirs [N_REQ];
  int order [9] = '{0, 1, 2, 3, 0, 3, 0, 3, 0};
  logic [1:0]       hold_id;
  logic [DIR_W-1:0] hold_dir;
  int               s0;

  initial begin
    reset = 1'b1; req_valid = '0; req_dir = '0; req_skip = '0; rsp_ready = 1'b1;
    div_skip_in = 1'b0; stub_en = 1'b1; man_valid = 1'b0; man_dir = '0; start_cnt = 0;
    dirs[0] = mk(16'h1000, 16'h2000, 16'h0800);
    dirs[1] = mk(16'h0400, 16'h1800, 16'hF000);
    dirs[2] = mk(16'h7FFF, 16'h0001, 16'h8000);
    dirs[3] = mk(16'h1234, 16'h5678, 16'h9ABC);
    for (int i = 0; i < N_REQ; i++) req_dir[i*DIR_W +: DIR_W] = dirs[i];
    step();
    step();
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_div_dir", {16'd0, div_dir}, 64'd0);
    chk("rst_rsp_dir", {16'd0, rsp_dir}, 64'd0);
    chk("rst_rsp_id", {62'd0, rsp_id}, 64'd0);
    chk("rst_err_timeout", {63'd0, err_timeout}, 64'd0);
    chk("rst_div_start", {63'd0, div_start}, 64'd0);
    reset = 1'b0;

    // Single request
    req_valid = 4'b0001;
    #1;
    chk("single_ready", {60'd0, req_ready}, 64'h1);
    step();
    req_valid = '0;
    chk("single_busy", {63'd0, busy}, 64'd1);
    wait_rsp("single_rsp_wait");
    chk("single_dir", {16'd0, rsp_dir}, {16'd0, mk(16'h1000, 16'h0800, 16'h2000)});
    chk("single_id", {62'd0, rsp_id}, 64'd0);
    chk("single_err", {63'd0, rsp_err}, 64'd0);
    chk("single_starts", 64'(start_cnt), 64'd1);
    step();
    chk("single_busy_fall", {63'd0, busy}, 64'd0);

    // Round-robin fairness
    do_reset();
    req_valid = 4'b1111;
    for (int k = 0; k < 9; k++) begin
      wait_rsp("rr_wait");
      chk("rr_id", {62'd0, rsp_id}, 64'(order[k]));
      chk("rr_dir", {16'd0, rsp_dir},
          {16'd0, dirs[order[k]][47:32], dirs[order[k]][15:0], dirs[order[k]][31:16]});
      if (k == 4) req_valid = 4'b1001;
      if (k == 8) req_valid = 4'b0000;
      step();
    end

    // Skip bypass on requester 2
    req_skip = 4'b0100;
    req_valid = 4'b0100;
    s0 = start_cnt;
    #1;
    chk("skip_ready", {60'd0, req_ready}, 64'h4);
    step();
    req_valid = '0;
    chk("skip_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("skip_id", {62'd0, rsp_id}, 64'd2);
    chk("skip_flag", {63'd0, rsp_skip}, 64'd1);
    chk("skip_dir", {16'd0, rsp_dir}, 64'd0);
    step();
    req_skip = '0;
    chk("skip_no_start", 64'(start_cnt), 64'(s0));
    chk("skip_idle", {63'd0, busy}, 64'd0);

    // Backpressure with requests 1 and 3 pending
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    step();
    req_valid = 4'b1010;
    wait_rsp("bp_wait");
    hold_id = rsp_id;
    hold_dir = rsp_dir;
    chk("bp_id", {62'd0, hold_id}, 64'd0);
    for (int c = 0; c < 20; c++) begin
      step();
      chk("bp_stall", {60'd0, rsp_valid, rsp_id == hold_id, rsp_dir == hold_dir, req_ready == 4'b0}, 64'hF);
    end
    rsp_ready = 1'b1;
    step();
    #1;
    chk("bp_next_grant", {60'd0, req_ready}, 64'h2);
    step();
    req_valid = '0;
    wait_rsp("bp_next_wait");
    chk("bp_next_id", {62'd0, rsp_id}, 64'd1);
    step();

    // Timeout with a silent divider
    stub_en = 1'b0;
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    wait_rsp("to_wait");
    chk("to_err", {63'd0, rsp_err}, 64'd1);
    chk("to_skip", {63'd0, rsp_skip}, 64'd1);
    chk("to_dir", {16'd0, rsp_dir}, 64'd0);
    chk("to_flag", {63'd0, err_timeout}, 64'd1);
    step();
    stub_en = 1'b1;
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    wait_rsp("to_after_wait");
    chk("to_after_id", {62'd0, rsp_id}, 64'd1);
    chk("to_after_err", {63'd0, rsp_err}, 64'd0);
    chk("to_sticky", {63'd0, err_timeout}, 64'd1);
    step();

    // Reset in the middle of WAIT
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    for (int c = 0; c < 5; c++) step();
    chk("mid_busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    step();
    chk("mid_rst_outs", {58'd0, busy, rsp_valid, div_start, err_timeout, rsp_id}, 64'd0);
    chk("mid_rst_dirs", {15'd0, (div_dir | rsp_dir) != '0}, 64'd0);
    reset = 1'b0;
    man_valid = 1'b1;
    man_dir = mk(16'hDEAD, 16'hBEEF, 16'hCAFE);
    step();
    man_valid = 1'b0;
    chk("stale_no_rsp", {62'd0, rsp_valid, busy}, 64'd0);
    req_valid = 4'b1010;
    #1;
    chk("mid_rr_reset", {60'd0, req_ready}, 64'h2);
    step();
    req_valid = '0;
    wait_rsp("mid_after_wait");
    chk("mid_after_id", {62'd0, rsp_id}, 64'd1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
